// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl: staggered reset release of NUM_DOM domains, then a budgeted run that ends on halt or timeout
module sopc_run_ctrl #(
    parameter int NUM_DOM     = 2,
    parameter int HOLD_CYCLES = 10,
    parameter int STAGGER     = 2,
    parameter int RUN_CYCLES  = 50,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt_i,
    input  logic               restart_i,
    output logic [NUM_DOM-1:0] dom_rst_o,
    output logic               running_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   cycle_cnt_o
);
    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_REL  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [31:0] HOLD_END = 32'(HOLD_CYCLES);
    localparam logic [31:0] REL_END  = 32'(HOLD_CYCLES + (NUM_DOM - 1) * STAGGER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);
    logic [1:0]         state_q, state_d;
    logic [31:0]        seq_q, seq_d;
    logic [NUM_DOM-1:0] dom_q, dom_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // next state: seq_q counts cycles since T0 and fixes every domain's release point
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        dom_d     = dom_q;
        running_d = running_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_HOLD, S_REL: begin
                seq_d = seq_q + 32'd1;
                for (int i = 0; i < NUM_DOM; i++)
                    dom_d[i] = seq_d < 32'(HOLD_CYCLES + i * STAGGER);
                if (seq_d == REL_END) begin
                    state_d   = S_RUN;
                    running_d = 1'b1;
                    cnt_d     = '0;
                end else if (seq_d >= HOLD_END) begin
                    state_d = S_REL;
                end
            end
            S_RUN: begin
                if (halt_i || cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = !halt_i;
                    dom_d     = '1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (restart_i) begin
                    state_d   = S_HOLD;
                    seq_d     = '0;
                    dom_d     = '1;
                    running_d = 1'b0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                end
            end
        endcase
    end
    // state and registered outputs, rst overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HOLD;
            seq_q     <= '0;
            dom_q     <= '1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            dom_q     <= dom_d;
            running_q <= running_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end
    assign dom_rst_o   = dom_q;
    assign running_o   = running_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign cycle_cnt_o = cnt_q;
endmodule
